// File: rtl/prog_check_runner.sv
// Program sequencer and self-checker: issues a table of instructions to a DUT, waits a fixed
// settle time, then compares the DUT output and register value against the table and tallies.
module prog_check_runner #(
  parameter int unsigned DW          = 8,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned AW          = $clog2(DEPTH),
  parameter int unsigned SETTLE      = 1,
  parameter bit          STOP_ON_ERR = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [DW-1:0] load_instr,
  input  logic [DW-1:0] load_exp_out,
  input  logic [DW-1:0] load_exp_reg,
  input  logic [AW:0]   prog_len,
  input  logic          start,
  output logic [DW-1:0] instr,
  output logic          instr_valid,
  input  logic [DW-1:0] dut_out,
  input  logic [DW-1:0] dut_reg,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [AW:0]   err_count,
  output logic          first_err_valid,
  output logic [AW-1:0] first_err,
  output logic [AW-1:0] cur_idx
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StIssue = 3'd1;
  localparam logic [2:0] StWait  = 3'd2;
  localparam logic [2:0] StCheck = 3'd3;
  localparam logic [2:0] StDone  = 3'd4;

  localparam logic [AW:0]   DepthW   = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CntOne   = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] IdxOne   = {{(AW - 1){1'b0}}, 1'b1};
  localparam logic [3:0]    SettleM1 = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;

  // Table storage has no reset so a loaded program survives a reset.
  logic [DW-1:0] mem_instr   [DEPTH];
  logic [DW-1:0] mem_exp_out [DEPTH];
  logic [DW-1:0] mem_exp_reg [DEPTH];

  logic [2:0]    state_q, state_d;
  logic [AW:0]   len_q, len_d;
  logic [3:0]    wait_q, wait_d;
  logic [DW-1:0] instr_q, instr_d;
  logic          instr_valid_q, instr_valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;
  logic [AW:0]   err_q, err_d;
  logic          fev_q, fev_d;
  logic [AW-1:0] fe_q, fe_d;
  logic [AW-1:0] cur_q, cur_d;
  logic          mismatch;
  logic          last;

  always_ff @(posedge clk) begin
    if (load_en && !busy_q) begin
      mem_instr[load_addr]   <= load_instr;
      mem_exp_out[load_addr] <= load_exp_out;
      mem_exp_reg[load_addr] <= load_exp_reg;
    end
  end

  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    wait_d        = wait_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    busy_d        = busy_q;
    done_d        = done_q;
    pass_d        = pass_q;
    err_d         = err_q;
    fev_d         = fev_q;
    fe_d          = fe_q;
    cur_d         = cur_q;
    mismatch      = (dut_out != mem_exp_out[cur_q]) || (dut_reg != mem_exp_reg[cur_q]);
    last          = ({1'b0, cur_q} == (len_q - CntOne));

    case (state_q)
      StIdle, StDone: begin
        // busy still set means DONE was just entered: publish the result this cycle.
        if (state_q == StDone && busy_q) begin
          busy_d        = 1'b0;
          instr_valid_d = 1'b0;
          instr_d       = '0;
          done_d        = 1'b1;
          pass_d        = (err_q == '0);
        end else if (start && !busy_q) begin
          len_d   = (prog_len > DepthW) ? DepthW : prog_len;
          err_d   = '0;
          fev_d   = 1'b0;
          fe_d    = '0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          cur_d   = '0;
          busy_d  = 1'b1;
          state_d = (len_d == '0) ? StDone : StIssue;
        end
      end
      StIssue: begin
        instr_d       = mem_instr[cur_q];
        instr_valid_d = 1'b1;
        wait_d        = 4'd0;
        state_d       = (SETTLE > 0) ? StWait : StCheck;
      end
      StWait: begin
        if (wait_q == SettleM1) begin
          state_d = StCheck;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      StCheck: begin
        if (mismatch) begin
          if (err_q != '1) begin
            err_d = err_q + CntOne;
          end
          if (!fev_q) begin
            fev_d = 1'b1;
            fe_d  = cur_q;
          end
        end
        if (last || (mismatch && STOP_ON_ERR)) begin
          state_d = StDone;
        end else begin
          cur_d   = cur_q + IdxOne;
          state_d = StIssue;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      len_q         <= '0;
      wait_q        <= '0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      err_q         <= '0;
      fev_q         <= 1'b0;
      fe_q          <= '0;
      cur_q         <= '0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      wait_q        <= wait_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      err_q         <= err_d;
      fev_q         <= fev_d;
      fe_q          <= fe_d;
      cur_q         <= cur_d;
    end
  end

  assign instr           = instr_q;
  assign instr_valid     = instr_valid_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign err_count       = err_q;
  assign first_err_valid = fev_q;
  assign first_err       = fe_q;
  assign cur_idx         = cur_q;

endmodule

// File: tb/tb_prog_check_runner.sv
// Bench for prog_check_runner: one continue-on-error and one stop-on-error instance share the
// load bus; stub DUTs answer with golden values, so corrupted table entries read as mismatches.
module tb_prog_check_runner;

  logic       clk;
  logic       rst_n;
  logic       load_en;
  logic [3:0] load_addr;
  logic [7:0] load_instr, load_exp_out, load_exp_reg;
  logic [4:0] prog_len;
  logic       start;

  logic [7:0] m_instr, m_dout, m_dreg;
  logic       m_iv, m_busy, m_done, m_pass, m_fev;
  logic [4:0] m_err;
  logic [3:0] m_fe, m_cur;

  logic [7:0] s_instr, s_dout, s_dreg;
  logic       s_iv, s_busy, s_done, s_pass, s_fev;
  logic [4:0] s_err;
  logic [3:0] s_fe, s_cur;

  int total = 0;
  int bad   = 0;

  logic [7:0] g_instr [16];
  logic [7:0] g_out   [16];
  logic [7:0] g_reg   [16];

  typedef struct {
    bit         v;
    logic [7:0] ins;
  } sb_t;
  sb_t sbq[$];

  typedef struct {
    int          plen;
    logic [15:0] mask;
    int          m_cyc;
    int          m_pass;
    int          m_err;
    int          m_fev;
    int          m_fe;
    int          m_cur;
    int          s_cyc;
    int          s_pass;
    int          s_err;
    int          s_fe;
    int          s_cur;
  } vec_t;

  prog_check_runner #(.SETTLE(1), .STOP_ON_ERR(1'b0)) u_main (
    .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_addr(load_addr),
    .load_instr(load_instr), .load_exp_out(load_exp_out), .load_exp_reg(load_exp_reg),
    .prog_len(prog_len), .start(start), .instr(m_instr), .instr_valid(m_iv),
    .dut_out(m_dout), .dut_reg(m_dreg), .busy(m_busy), .done(m_done), .pass(m_pass),
    .err_count(m_err), .first_err_valid(m_fev), .first_err(m_fe), .cur_idx(m_cur)
  );

  prog_check_runner #(.SETTLE(1), .STOP_ON_ERR(1'b1)) u_stop (
    .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_addr(load_addr),
    .load_instr(load_instr), .load_exp_out(load_exp_out), .load_exp_reg(load_exp_reg),
    .prog_len(prog_len), .start(start), .instr(s_instr), .instr_valid(s_iv),
    .dut_out(s_dout), .dut_reg(s_dreg), .busy(s_busy), .done(s_done), .pass(s_pass),
    .err_count(s_err), .first_err_valid(s_fev), .first_err(s_fe), .cur_idx(s_cur)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stub DUTs: always return the golden pair for whatever instruction they see.
  always_comb begin
    m_dout = 8'h00;
    m_dreg = 8'h00;
    s_dout = 8'h00;
    s_dreg = 8'h00;
    for (int i = 0; i < 16; i++) begin
      if (g_instr[i] == m_instr) begin
        m_dout = g_out[i];
        m_dreg = g_reg[i];
      end
      if (g_instr[i] == s_instr) begin
        s_dout = g_out[i];
        s_dreg = g_reg[i];
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(posedge clk) begin : monitor
    sb_t it;
    #1;
    if (sbq.size() > 0) begin
      it = sbq.pop_front();
      chk("sb_instr_valid", int'(m_iv), int'(it.v));
      if (it.v) chk("sb_instr", int'(m_instr), int'(it.ins));
    end
  end

  task automatic load_table(input logic [15:0] mask);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      load_en      = 1'b1;
      load_addr    = 4'(i);
      load_instr   = g_instr[i];
      load_exp_out = g_out[i] ^ {7'd0, mask[i]};
      load_exp_reg = g_reg[i];
    end
    @(negedge clk);
    load_en = 1'b0;
  endtask

  // Starts a run, queues the expected instr stream, returns the edge index at which each
  // instance first shows done (-1 if it never did within the budget).
  task automatic run(input int plen, input bit poke, output int mc, output int sc);
    int  len;
    sb_t it;
    len = (plen > 16) ? 16 : plen;
    mc  = -1;
    sc  = -1;
    @(negedge clk);
    prog_len = 5'(plen);
    start    = 1'b1;
    it.v     = 1'b0;
    it.ins   = 8'h00;
    sbq.push_back(it);
    for (int e = 0; e < len; e++) begin
      for (int r = 0; r < 3; r++) begin
        it.v   = 1'b1;
        it.ins = g_instr[e];
        sbq.push_back(it);
      end
    end
    for (int k = 0; k < 200 && (mc < 0 || sc < 0); k++) begin
      @(posedge clk);
      #1;
      if (k == 0) begin
        start = 1'b0;
        chk("start_clr_done", int'(m_done), 0);
        chk("start_clr_pass", int'(m_pass), 0);
        chk("start_clr_err", int'(m_err), 0);
        chk("start_clr_fev", int'(m_fev), 0);
        if (len > 0) chk("start_busy", int'(m_busy), 1);
      end
      if (poke) begin
        if (k == 3) begin
          load_en      = 1'b1;
          load_addr    = 4'd0;
          load_instr   = 8'hFF;
          load_exp_out = 8'hFF;
          load_exp_reg = 8'hFF;
        end
        if (k == 5) start = 1'b1;
        if (k == 6) begin
          start   = 1'b0;
          load_en = 1'b0;
        end
      end
      if (m_done && mc < 0) mc = k;
      if (s_done && sc < 0) sc = k;
    end
  endtask

  initial begin
    vec_t vecs[5];
    int   mc, sc;

    g_instr[0] = 8'h8D; g_out[0] = 8'h0D; g_reg[0] = 8'h0D;
    g_instr[1] = 8'h00; g_out[1] = 8'h00; g_reg[1] = 8'h0D;
    g_instr[2] = 8'h30; g_out[2] = 8'hF2; g_reg[2] = 8'h0D;
    g_instr[3] = 8'h12; g_out[3] = 8'h1A; g_reg[3] = 8'h0D;
    g_instr[4] = 8'h82; g_out[4] = 8'h0F; g_reg[4] = 8'h0F;
    for (int i = 5; i < 16; i++) begin
      g_instr[i] = 8'h40 + 8'(i);
      g_out[i]   = g_instr[i] ^ 8'h5A;
      g_reg[i]   = g_instr[i] + 8'd3;
    end

    // plen, mask, main{cyc,pass,err,fev,fe,cur}, stop{cyc,pass,err,fe,cur}; cur -1 = unchecked
    vecs[0] = '{5,  16'h0000, 16, 1, 0, 0, 0,  4,  16, 1, 0, 0,  4};
    vecs[1] = '{5,  16'h0004, 16, 0, 1, 1, 2,  4,  10, 0, 1, 2,  2};
    vecs[2] = '{5,  16'h000A, 16, 0, 2, 1, 1,  4,  7,  0, 1, 1,  1};
    vecs[3] = '{0,  16'h0000, 1,  1, 0, 0, 0,  -1, 1,  1, 0, 0,  -1};
    vecs[4] = '{20, 16'h8000, 49, 0, 1, 1, 15, 15, 49, 0, 1, 15, 15};

    rst_n        = 1'b0;
    load_en      = 1'b0;
    load_addr    = '0;
    load_instr   = '0;
    load_exp_out = '0;
    load_exp_reg = '0;
    prog_len     = '0;
    start        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_instr", int'(m_instr), 0);
    chk("rst_instr_valid", int'(m_iv), 0);
    chk("rst_busy", int'(m_busy), 0);
    chk("rst_done", int'(m_done), 0);
    chk("rst_pass", int'(m_pass), 0);
    chk("rst_err", int'(m_err), 0);
    chk("rst_fev", int'(m_fev), 0);
    chk("rst_cur", int'(m_cur), 0);
    chk("rst_stop_busy", int'(s_busy), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int r = 0; r < 5; r++) begin
      load_table(vecs[r].mask);
      run(vecs[r].plen, 1'b0, mc, sc);
      chk($sformatf("v%0d main_done_edge", r), mc, vecs[r].m_cyc);
      chk($sformatf("v%0d main_pass", r), int'(m_pass), vecs[r].m_pass);
      chk($sformatf("v%0d main_err", r), int'(m_err), vecs[r].m_err);
      chk($sformatf("v%0d main_fev", r), int'(m_fev), vecs[r].m_fev);
      chk($sformatf("v%0d main_first_err", r), int'(m_fe), vecs[r].m_fe);
      if (vecs[r].m_cur >= 0) chk($sformatf("v%0d main_cur", r), int'(m_cur), vecs[r].m_cur);
      chk($sformatf("v%0d main_busy", r), int'(m_busy), 0);
      chk($sformatf("v%0d main_iv", r), int'(m_iv), 0);
      chk($sformatf("v%0d main_instr", r), int'(m_instr), 0);
      chk($sformatf("v%0d stop_done_edge", r), sc, vecs[r].s_cyc);
      chk($sformatf("v%0d stop_pass", r), int'(s_pass), vecs[r].s_pass);
      chk($sformatf("v%0d stop_err", r), int'(s_err), vecs[r].s_err);
      chk($sformatf("v%0d stop_fev", r), int'(s_fev), (vecs[r].s_err > 0) ? 1 : 0);
      chk($sformatf("v%0d stop_first_err", r), int'(s_fe), vecs[r].s_fe);
      if (vecs[r].s_cur >= 0) chk($sformatf("v%0d stop_cur", r), int'(s_cur), vecs[r].s_cur);
    end

    // Loads and start pulses during a run are ignored; the next run sees the original entry 0.
    load_table(16'h0000);
    run(5, 1'b1, mc, sc);
    chk("poke_done_edge", mc, 16);
    chk("poke_pass", int'(m_pass), 1);
    run(5, 1'b0, mc, sc);
    chk("after_poke_done_edge", mc, 16);
    chk("after_poke_pass", int'(m_pass), 1);
    chk("after_poke_err", int'(m_err), 0);

    // Restart from DONE after a failing run: counters clear, run repeats.
    load_table(16'h000A);
    run(5, 1'b0, mc, sc);
    chk("redo1_err", int'(m_err), 2);
    chk("redo1_done", int'(m_done), 1);
    run(5, 1'b0, mc, sc);
    chk("redo2_done_edge", mc, 16);
    chk("redo2_err", int'(m_err), 2);
    chk("redo2_first_err", int'(m_fe), 1);

    // Reset during entry 2 aborts; table survives, so a rerun passes.
    load_table(16'h0000);
    @(negedge clk);
    prog_len = 5'd5;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("pre_rst_busy", int'(m_busy), 1);
    chk("pre_rst_cur", int'(m_cur), 2);
    @(negedge clk);
    rst_n = 1'b0;
    sbq.delete();
    @(posedge clk);
    #1;
    chk("midrst_busy", int'(m_busy), 0);
    chk("midrst_done", int'(m_done), 0);
    chk("midrst_iv", int'(m_iv), 0);
    chk("midrst_err", int'(m_err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run(5, 1'b0, mc, sc);
    chk("post_rst_done_edge", mc, 16);
    chk("post_rst_pass", int'(m_pass), 1);
    chk("post_rst_err", int'(m_err), 0);

    repeat (2) @(posedge clk);
    #2;
    chk("sb_drained", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prog_check_runner.md
Name: prog_check_runner

Overview:
- Clocked, synthesizable program sequencer and self-checker for the 8-bit CPU core and its successors.
- Holds a loadable table of instruction / expected-output / expected-register triples, then issues each instruction to the DUT in turn.
- Waits a programmable settle time, compares the DUT outputs and register value against the table, and tallies the results.
- Replaces fixed-delay, unclocked stimulus loops with a parametrised, cycle-exact, reusable harness.

Parameters:
- DW, 8, data width of instructions, DUT outputs and expected values
- DEPTH, 16, number of table entries (power of two, ≥2)
- AW, $clog2(DEPTH), index width (derived; do not override)
- SETTLE, 1, wait cycles between instruction issue and compare (0..15)
- STOP_ON_ERR, 0, 1 = terminate run at the first mismatch

Ports:
- clk  in  1  clock, all state changes on rising edge
- rst_n  in  1  synchronous active-low reset
- load_en  in  1  write one table entry this cycle
- load_addr  in  AW  table entry index to write
- load_instr  in  DW  instruction to store
- load_exp_out  in  DW  expected DUT output
- load_exp_reg  in  DW  expected DUT register value
- prog_len  in  AW+1  number of entries to run (sampled at start)
- start  in  1  begin run (single-cycle pulse or level)
- instr  out  DW  instruction driven to DUT
- instr_valid  out  1  instr is meaningful
- dut_out  in  DW  DUT primary output
- dut_reg  in  DW  DUT register output
- busy  out  1  run in progress
- done  out  1  run finished; held until next start or reset
- pass  out  1  valid when done: no mismatches
- err_count  out  AW+1  mismatching entries, saturating
- first_err_valid  out  1  at least one mismatch recorded
- first_err  out  AW  index of first mismatch
- cur_idx  out  AW  index of entry being issued/checked

Behaviour:
- Reset (rst_n=0 at edge):
  - state=IDLE; every output 0.
  - Table contents are NOT cleared; they survive reset.
  - Reset mid-run aborts immediately. busy/done/instr_valid are 0 on the following cycle.
- Table writes:
  - Accepted only when busy=0: mem[load_addr] <= {load_instr, load_exp_out, load_exp_reg}.
  - Ignored while busy=1.
- FSM states: IDLE, ISSUE, WAIT, CHECK, DONE.
- IDLE/DONE + start:
  - Latch len = min(prog_len, DEPTH).
  - Clear err_count, first_err_valid, first_err, done and pass.
  - If len=0: go to DONE with pass=1 (done=1 on the next cycle).
  - Otherwise: cur_idx=0, go to ISSUE.
- start while busy is ignored. A held start re-triggers only from DONE/IDLE.
- ISSUE (1 cycle):
  - instr <= mem[cur_idx].instr; instr_valid=1; busy=1.
  - Next state is WAIT if SETTLE>0, else CHECK.
- WAIT: stay SETTLE cycles, counted by an internal counter; instr held stable.
- CHECK (1 cycle):
  - mismatch = (dut_out != exp_out) || (dut_reg != exp_reg).
  - On mismatch: err_count++ (saturate at all-ones). If first_err_valid=0, set it and set first_err=cur_idx.
  - Exit to DONE if cur_idx==len-1, or if mismatch && STOP_ON_ERR=1.
  - Otherwise cur_idx++ and go to ISSUE.
- Timing:
  - Each entry occupies SETTLE+2 cycles; instr_valid stays 1 continuously across entries.
  - For start sampled at edge 0, done=1 is visible after edge len*(SETTLE+2)+1.
- DONE:
  - busy=0, instr_valid=0, instr=0, done=1.
  - pass = (err_count==0).
  - cur_idx holds the last checked index.

Test Plan:
- Table {8D/0D/0D, 00/00/0D, 30/F2/0D, 12/1A/0D, 82/0F/0F}, stub DUT returning the expected pair per instr, SETTLE=1, prog_len=5, start at edge 0 → done=1 after edge 16, pass=1, err_count=0, first_err_valid=0, instr_valid high edges 1–15.
- Same run with entry 2 exp_out=F3 → pass=0, err_count=1, first_err_valid=1, first_err=2, cur_idx=4.
- STOP_ON_ERR=1, mismatches at entries 1 and 3 → done after entry 1 CHECK (edge 7), err_count=1, first_err=1, cur_idx=1.
- prog_len=0 → done=1 and pass=1 one cycle after start. prog_len=20 with DEPTH=16 → exactly 16 entries checked.
- rst_n=0 for one edge during entry 2 → next cycle busy=done=instr_valid=err_count=0. Restart then reruns entries 0–4 from the retained table with pass=1.
- load_en with load_addr=0, data FF/FF/FF while busy → table unchanged. start pulses during run → ignored. start in DONE → counters cleared, new run begins.
